// File: rtl/jtpopeye_inputs_pkg.sv
// Shared constants for the Popeye cabinet-input conditioning block:
// PS/2 scan codes, held-key vector layout and MiSTer joystick bit positions.
package jtpopeye_inputs_pkg;

  // PS/2 set-2 scan codes recognised by the key decoder
  localparam logic [7:0] KEY_UP     = 8'h75;
  localparam logic [7:0] KEY_DOWN   = 8'h72;
  localparam logic [7:0] KEY_LEFT   = 8'h6B;
  localparam logic [7:0] KEY_RIGHT  = 8'h74;
  localparam logic [7:0] KEY_PUNCH  = 8'h14;
  localparam logic [7:0] KEY_START1 = 8'h05;
  localparam logic [7:0] KEY_START2 = 8'h06;
  localparam logic [7:0] KEY_COIN   = 8'h04;
  localparam logic [7:0] KEY_PAUSE  = 8'h0C;

  // Held-key vector layout. Bits 0..4 deliberately line up with the
  // joystick bits so the merge is a straight bitwise OR.
  localparam int NKEYS     = 9;
  localparam int KI_RIGHT  = 0;
  localparam int KI_LEFT   = 1;
  localparam int KI_DOWN   = 2;
  localparam int KI_UP     = 3;
  localparam int KI_PUNCH  = 4;
  localparam int KI_START1 = 5;
  localparam int KI_START2 = 6;
  localparam int KI_COIN   = 7;
  localparam int KI_PAUSE  = 8;

  // MiSTer joystick word bit positions
  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_PUNCH  = 4;
  localparam int JB_START1 = 6;
  localparam int JB_START2 = 7;
  localparam int JB_COIN   = 8;
  localparam int JB_PAUSE  = 9;

  // One-hot match of a scan code against the key table; all-zero if unknown
  function automatic logic [NKEYS-1:0] key_match(input logic [7:0] code);
    logic [NKEYS-1:0] hit;
    hit = '0;
    hit[KI_RIGHT]  = (code == KEY_RIGHT);
    hit[KI_LEFT]   = (code == KEY_LEFT);
    hit[KI_DOWN]   = (code == KEY_DOWN);
    hit[KI_UP]     = (code == KEY_UP);
    hit[KI_PUNCH]  = (code == KEY_PUNCH);
    hit[KI_START1] = (code == KEY_START1);
    hit[KI_START2] = (code == KEY_START2);
    hit[KI_COIN]   = (code == KEY_COIN);
    hit[KI_PAUSE]  = (code == KEY_PAUSE);
    return hit;
  endfunction

  // OSD difficulty (0 normal, 1 easy, 2 hard, 3 very hard) to game dip_level
  function automatic logic [1:0] level_map(input logic [1:0] osd);
    logic [1:0] lvl;
    case (osd)
      2'd0:    lvl = 2'd2;
      2'd1:    lvl = 2'd3;
      2'd2:    lvl = 2'd1;
      default: lvl = 2'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/jtpopeye_ps2_keys.sv
// PS/2 key-event decoder: turns toggle-flagged key events into a vector of
// held key states. The first clock after reset only captures the toggle bit
// so a stale toggle value cannot be mistaken for a fresh event.
module jtpopeye_ps2_keys
  import jtpopeye_inputs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      ps2_key,
  output logic [NKEYS-1:0] keys
);

  logic             primed_q;
  logic             shadow_q;
  logic [NKEYS-1:0] keys_q;
  logic [NKEYS-1:0] keys_d;
  logic [NKEYS-1:0] hit;
  logic             evt;

  // The extended-key flag carries no meaning for this cabinet
  logic unused_ext;
  assign unused_ext = ps2_key[8];

  assign hit = key_match(ps2_key[7:0]);
  assign evt = primed_q && (ps2_key[10] != shadow_q);

  // Only the matched key register follows the pressed flag on an event
  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
      assign keys_d[gi] = (evt && hit[gi]) ? ps2_key[9] : keys_q[gi];
    end
  endgenerate

  // Shadow tracks the toggle bit every clock; primed set after first clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_q <= 1'b0;
      shadow_q <= 1'b0;
      keys_q   <= '0;
    end else begin
      primed_q <= 1'b1;
      shadow_q <= ps2_key[10];
      keys_q   <= keys_d;
    end
  end

  assign keys = keys_q;

endmodule

// File: rtl/jtpopeye_inputs.sv
// Cabinet-input conditioning for jtpopeye_game: merges PS/2 keys with the
// MiSTer joysticks, stretches the coin pulse, handles the pause toggle and
// maps the OSD difficulty. Every output comes straight from a register.
module jtpopeye_inputs
  import jtpopeye_inputs_pkg::*;
#(
  parameter int COIN_MIN = 800000,
  parameter int CW       = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        pause_clr,
  input  logic [1:0]  osd_level,
  output logic [4:0]  joystick1,
  output logic [4:0]  joystick2,
  output logic [1:0]  start_button,
  output logic        coin_input,
  output logic        pause,
  output logic [1:0]  dip_level
);

  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_MIN - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [NKEYS-1:0] keys;

  logic [4:0]    joy1_m;
  logic [1:0]    start_m;
  logic          coin_m;
  logic          pause_m;

  logic [4:0]    joy1_q, joy2_q;
  logic [1:0]    start_q;
  logic          coin_q, coin_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pause_in_q, pause_prev_q, pause_q, pause_d;
  logic [1:0]    dip_q;

  // Joystick bits with no function in this game
  logic unused_joy;
  assign unused_joy = ^{joy_0[15:10], joy_0[5], joy_1[15:5]};

  jtpopeye_ps2_keys u_keys (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_key (ps2_key),
    .keys    (keys)
  );

  // Directions and punch share bit positions between keys and joystick
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_joy_merge
      assign joy1_m[gi] = keys[gi] | joy_0[gi];
    end
  endgenerate

  assign start_m = {keys[KI_START2] | joy_0[JB_START2],
                    keys[KI_START1] | joy_0[JB_START1]};
  assign coin_m  = keys[KI_COIN]  | joy_0[JB_COIN];
  assign pause_m = keys[KI_PAUSE] | joy_0[JB_PAUSE];

  // Coin counter: reload on every rising edge, otherwise count down to 0
  always_comb begin
    cnt_d = cnt_q;
    if (coin_m && !coin_prev_q)
      cnt_d = COIN_LOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_ONE;
  end

  // Pause toggles on a rising edge of the registered merge; clear dominates
  always_comb begin
    pause_d = pause_q;
    if (pause_clr)
      pause_d = 1'b0;
    else if (pause_in_q && !pause_prev_q)
      pause_d = ~pause_q;
  end

  // Output and state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy1_q       <= '0;
      joy2_q       <= '0;
      start_q      <= '0;
      coin_q       <= 1'b0;
      coin_prev_q  <= 1'b0;
      cnt_q        <= '0;
      pause_in_q   <= 1'b0;
      pause_prev_q <= 1'b0;
      pause_q      <= 1'b0;
      dip_q        <= '0;
    end else begin
      joy1_q       <= joy1_m;
      joy2_q       <= joy_1[4:0];
      start_q      <= start_m;
      coin_q       <= coin_m | (cnt_q != '0);
      coin_prev_q  <= coin_m;
      cnt_q        <= cnt_d;
      pause_in_q   <= pause_m;
      pause_prev_q <= pause_in_q;
      pause_q      <= pause_d;
      dip_q        <= level_map(osd_level);
    end
  end

  assign joystick1    = joy1_q;
  assign joystick2    = joy2_q;
  assign start_button = start_q;
  assign coin_input   = coin_q;
  assign pause        = pause_q;
  assign dip_level    = dip_q;

endmodule

// File: tb/tb_jtpopeye_inputs.sv
// Scoreboard bench for jtpopeye_inputs: stimulus pushes cycle-tagged expected
// outputs, a negedge monitor pops and compares them as the cycles arrive.
module tb_jtpopeye_inputs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ps2_key;
  logic [15:0] joy_0, joy_1;
  logic        pause_clr;
  logic [1:0]  osd_level;
  logic [4:0]  joystick1, joystick2;
  logic [1:0]  start_button;
  logic        coin_input, pause;
  logic [1:0]  dip_level;

  jtpopeye_inputs #(.COIN_MIN(16), .CW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_key      (ps2_key),
    .joy_0        (joy_0),
    .joy_1        (joy_1),
    .pause_clr    (pause_clr),
    .osd_level    (osd_level),
    .joystick1    (joystick1),
    .joystick2    (joystick2),
    .start_button (start_button),
    .coin_input   (coin_input),
    .pause        (pause),
    .dip_level    (dip_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Packed output word: [15:11] j1, [10:6] j2, [5:4] start, [3] coin, [2] pause, [1:0] dip
  localparam logic [15:0] M_ALL   = 16'hFFFF;
  localparam logic [15:0] M_J1    = 16'hF800;
  localparam logic [15:0] M_J2    = 16'h07C0;
  localparam logic [15:0] M_ST    = 16'h0030;
  localparam logic [15:0] M_COIN  = 16'h0008;
  localparam logic [15:0] M_PAUSE = 16'h0004;
  localparam logic [15:0] M_DIP   = 16'h0003;
  localparam logic [15:0] IDLE    = 16'h0002;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic [15:0] mask;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [15:0] outv();
    return {joystick1, joystick2, start_button, coin_input, pause, dip_level};
  endfunction

  function automatic logic [15:0] J1(input logic [4:0] v); return {v, 11'd0}; endfunction
  function automatic logic [15:0] J2(input logic [4:0] v); return {5'd0, v, 6'd0}; endfunction
  function automatic logic [15:0] ST(input logic [1:0] v); return {10'd0, v, 4'd0}; endfunction
  function automatic logic [15:0] CO(input logic v);       return {12'd0, v, 3'd0}; endfunction
  function automatic logic [15:0] PA(input logic v);       return {13'd0, v, 2'd0}; endfunction
  function automatic logic [15:0] DL(input logic [1:0] v); return {14'd0, v}; endfunction

  task automatic compare(input string nm, input logic [15:0] want, input logic [15:0] mask);
    logic [15:0] got;
    got = outv();
    n_vec++;
    if (((got ^ want) & mask) != 16'h0) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h mask=%h", nm, cyc, got & mask, want & mask, mask);
    end else begin
      $display("ok   %s cyc=%0d value=%h mask=%h", nm, cyc, got & mask, mask);
    end
  endtask

  task automatic exp_at(input int dly, input logic [15:0] val, input logic [15:0] mask, input string nm);
    exp_t e;
    e.cyc = cyc + dly; e.val = val; e.mask = mask; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2(input logic pressed, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s missed cyc=%0d now=%0d", e.nm, e.cyc, cyc);
      end else begin
        compare(e.nm, e.val, e.mask);
      end
    end
  end

  initial begin
    logic [1:0] lvl_tab [4];
    int w;
    lvl_tab[0] = 2'd2; lvl_tab[1] = 2'd3; lvl_tab[2] = 2'd1; lvl_tab[3] = 2'd0;

    // Toggle bit high with a valid code held through reset: must not fire
    ps2_key   = {1'b1, 1'b1, 1'b0, 8'h75};
    joy_0     = '0;
    joy_1     = '0;
    pause_clr = 1'b0;
    osd_level = 2'd0;
    #1 compare("reset_state", 16'h0000, M_ALL);
    tick(3);
    rst_n = 1'b1;
    exp_at(1, IDLE, M_ALL, "release_c1");
    exp_at(2, IDLE, M_ALL, "release_c2");
    exp_at(3, IDLE, M_ALL, "release_c3");
    tick(5);

    // PS/2 up press and release, 2-clock latency
    exp_at(1, J1(5'b00000), M_J1, "up_press_c1");
    exp_at(2, J1(5'b01000), M_J1, "up_press_c2");
    ps2(1'b1, 8'h75); tick(3);
    exp_at(1, J1(5'b01000), M_J1, "up_rel_c1");
    exp_at(2, J1(5'b00000), M_J1, "up_rel_c2");
    ps2(1'b0, 8'h75); tick(3);

    // Press and release on consecutive clocks: one-clock punch
    exp_at(1, J1(5'b00000), M_J1, "punch_c1");
    exp_at(2, J1(5'b10000), M_J1, "punch_c2");
    exp_at(3, J1(5'b00000), M_J1, "punch_c3");
    ps2(1'b1, 8'h14); tick(1);
    ps2(1'b0, 8'h14); tick(4);

    // Unknown code is ignored
    exp_at(2, IDLE, M_ALL, "unmatched");
    ps2(1'b1, 8'h55); tick(3);

    // PS/2 start1 and start2
    exp_at(2, ST(2'b01), M_ST, "key_start1");
    ps2(1'b1, 8'h05); tick(3);
    exp_at(2, ST(2'b11), M_ST, "key_start2");
    ps2(1'b1, 8'h06); tick(3);
    exp_at(2, ST(2'b10), M_ST, "key_start1_rel");
    ps2(1'b0, 8'h05); tick(3);
    exp_at(2, ST(2'b00), M_ST, "key_start2_rel");
    ps2(1'b0, 8'h06); tick(3);

    // Joystick merge, 1-clock latency
    exp_at(1, J1(5'b10101) | ST(2'b11), M_J1 | M_ST, "joy0_bits");
    joy_0 = 16'h00D5; tick(2);
    exp_at(1, IDLE, M_ALL, "joy0_clear");
    joy_0 = 16'h0000; tick(2);
    exp_at(1, J2(5'b10101), M_J2, "joy1_bits");
    joy_1 = 16'hFFF5; tick(2);
    exp_at(1, J2(5'b00000), M_J2, "joy1_clear");
    joy_1 = 16'h0000; tick(2);

    // One-clock coin pulse: high for exactly 16 clocks
    exp_at(1,  CO(1'b1), M_COIN, "coin1_start");
    exp_at(16, CO(1'b1), M_COIN, "coin1_last");
    exp_at(17, CO(1'b0), M_COIN, "coin1_end");
    joy_0[8] = 1'b1; tick(1); joy_0[8] = 1'b0; tick(20);

    // Second pulse 10 clocks later reloads: high through clock 26
    exp_at(1,  CO(1'b1), M_COIN, "coin2_start");
    exp_at(17, CO(1'b1), M_COIN, "coin2_ext");
    exp_at(26, CO(1'b1), M_COIN, "coin2_last");
    exp_at(27, CO(1'b0), M_COIN, "coin2_end");
    joy_0[8] = 1'b1; tick(1); joy_0[8] = 1'b0; tick(9);
    joy_0[8] = 1'b1; tick(1); joy_0[8] = 1'b0; tick(20);

    // Source held longer than COIN_MIN
    exp_at(20, CO(1'b1), M_COIN, "coin_held_last");
    exp_at(21, CO(1'b0), M_COIN, "coin_held_end");
    joy_0[8] = 1'b1; tick(20); joy_0[8] = 1'b0; tick(4);

    // PS/2 coin key
    exp_at(1, CO(1'b0), M_COIN, "key_coin_c1");
    exp_at(2, CO(1'b1), M_COIN, "key_coin_c2");
    ps2(1'b1, 8'h04); tick(1); ps2(1'b0, 8'h04); tick(20);

    // Joystick pause: toggles 2 clocks after the edge
    exp_at(1, PA(1'b0), M_PAUSE, "jpause1_c1");
    exp_at(2, PA(1'b1), M_PAUSE, "jpause1_c2");
    joy_0[9] = 1'b1; tick(1); joy_0[9] = 1'b0; tick(4);
    exp_at(1, PA(1'b1), M_PAUSE, "jpause2_c1");
    exp_at(2, PA(1'b0), M_PAUSE, "jpause2_c2");
    joy_0[9] = 1'b1; tick(1); joy_0[9] = 1'b0; tick(4);

    // PS/2 pause: 3 clocks; release must not toggle
    exp_at(2, PA(1'b0), M_PAUSE, "kpause_c2");
    exp_at(3, PA(1'b1), M_PAUSE, "kpause_c3");
    ps2(1'b1, 8'h0C); tick(5);
    exp_at(4, PA(1'b1), M_PAUSE, "kpause_rel");
    ps2(1'b0, 8'h0C); tick(5);

    // pause_clr alone clears on the next edge
    exp_at(1, PA(1'b0), M_PAUSE, "pause_clr");
    pause_clr = 1'b1; tick(1); pause_clr = 1'b0; tick(3);

    // pause_clr wins over a simultaneous rising edge
    exp_at(2, PA(1'b0), M_PAUSE, "clr_wins_c2");
    exp_at(3, PA(1'b0), M_PAUSE, "clr_wins_c3");
    pause_clr = 1'b1; joy_0[9] = 1'b1; tick(1);
    joy_0[9] = 1'b0; tick(2);
    pause_clr = 1'b0; tick(3);

    // Held pause toggles only once
    exp_at(2, PA(1'b1), M_PAUSE, "hold_c2");
    exp_at(6, PA(1'b1), M_PAUSE, "hold_c6");
    joy_0[9] = 1'b1; tick(6); joy_0[9] = 1'b0; tick(3);

    // Level sweep
    for (int i = 0; i < 4; i++) begin
      osd_level = 2'(i);
      exp_at(1, DL(lvl_tab[i]), M_DIP, $sformatf("level_%0d", i));
      tick(2);
    end
    osd_level = 2'd0; tick(2);

    // Asynchronous reset in the middle of a coin stretch
    joy_0[8] = 1'b1; tick(1); joy_0[8] = 1'b0; tick(5);
    #2 compare("pre_reset_coin", CO(1'b1), M_COIN);
    rst_n = 1'b0;
    #1 compare("async_reset", 16'h0000, M_ALL);
    tick(2);
    rst_n = 1'b1;
    exp_at(1, IDLE, M_ALL, "after_reset_c1");
    exp_at(3, IDLE, M_ALL, "after_reset_c3");
    tick(4);

    // Drain the scoreboard with a bound
    w = 0;
    while (sb.size() > 0 && w < 50) begin
      tick(1);
      w++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
